// File: rtl/qdec_cabac_ctu_sequencer.sv
// qdec_cabac_ctu_sequencer
//   Slice-level control stage downstream of the CABAC register block. On
//   cabac_start it samples the picture/CTB geometry, derives the picture size
//   in CTBs, requests context initialisation and then issues CTUs in raster
//   order to the CTU parser, one at a time. The run ends on the parser's
//   end_of_slice_segment_flag or after the last CTU, with a done pulse and a
//   status word.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   cabac_start    1-cycle start pulse (ignored while busy)
//   pic_width      picture width in luma samples
//   pic_height     picture height in luma samples
//   log2_ctb_size  CtbLog2SizeY, legal 4..6
//   init_req       context-init request, held until init_done
//   init_done      1-cycle ack from the context-init block
//   ctu_start      1-cycle pulse: parse CTU at ctu_x/ctu_y
//   ctu_x, ctu_y   CTB column/row of the current CTU
//   ctu_addr       raster CTB address
//   ctu_done       1-cycle pulse: current CTU parsed
//   ctu_eos        end_of_slice_segment_flag, valid with ctu_done
//   busy           high from the cycle after cabac_start until done
//   done           1-cycle completion pulse
//   status         [0] bad geometry, [1] last CTU reached without eos
module qdec_cabac_ctu_sequencer #(
    parameter int CTB_CNT_W = 12,
    parameter int PIC_DIM_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cabac_start,
    input  logic [PIC_DIM_W-1:0]   pic_width,
    input  logic [PIC_DIM_W-1:0]   pic_height,
    input  logic [2:0]             log2_ctb_size,
    output logic                   init_req,
    input  logic                   init_done,
    output logic                   ctu_start,
    output logic [CTB_CNT_W-1:0]   ctu_x,
    output logic [CTB_CNT_W-1:0]   ctu_y,
    output logic [2*CTB_CNT_W-1:0] ctu_addr,
    input  logic                   ctu_done,
    input  logic                   ctu_eos,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_INIT,
        S_ISSUE,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [PIC_DIM_W:0] DIM_ONE = 1;

    state_t                 state;
    logic [PIC_DIM_W-1:0]   geo_w;
    logic [PIC_DIM_W-1:0]   geo_h;
    logic [2:0]             geo_log2;
    logic [CTB_CNT_W-1:0]   width_m1;
    logic [CTB_CNT_W-1:0]   height_m1;

    // Size-in-CTB arithmetic is one bit wider than the picture dimension so
    // that rounding up a dimension near full scale cannot wrap.
    logic [PIC_DIM_W:0]     round_add;
    logic [PIC_DIM_W:0]     w_sum;
    logic [PIC_DIM_W:0]     h_sum;
    logic [PIC_DIM_W:0]     w_ctb;
    logic [PIC_DIM_W:0]     h_ctb;
    logic [PIC_DIM_W:0]     w_m1;
    logic [PIC_DIM_W:0]     h_m1;
    logic                   geo_bad;
    logic                   last_x;
    logic                   last_y;

    always_comb begin
        round_add = (DIM_ONE << geo_log2) - DIM_ONE;
        w_sum     = {1'b0, geo_w} + round_add;
        h_sum     = {1'b0, geo_h} + round_add;
        w_ctb     = w_sum >> geo_log2;
        h_ctb     = h_sum >> geo_log2;
        w_m1      = w_ctb - DIM_ONE;
        h_m1      = h_ctb - DIM_ONE;
        // Besides the illegal CTB sizes and empty pictures, a CTB count that
        // does not fit the column/row counters is also rejected.
        geo_bad   = (geo_log2 < 3'd4) || (geo_log2 > 3'd6) ||
                    (geo_w == '0) || (geo_h == '0) ||
                    (w_m1[PIC_DIM_W:CTB_CNT_W] != '0) ||
                    (h_m1[PIC_DIM_W:CTB_CNT_W] != '0);
        last_x    = (ctu_x == width_m1);
        last_y    = (ctu_y == height_m1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            geo_w     <= '0;
            geo_h     <= '0;
            geo_log2  <= '0;
            width_m1  <= '0;
            height_m1 <= '0;
            init_req  <= 1'b0;
            ctu_start <= 1'b0;
            ctu_x     <= '0;
            ctu_y     <= '0;
            ctu_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cabac_start) begin
                        geo_w    <= pic_width;
                        geo_h    <= pic_height;
                        geo_log2 <= log2_ctb_size;
                        status   <= '0;
                        busy     <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (geo_bad) begin
                        status[0] <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        width_m1  <= w_m1[CTB_CNT_W-1:0];
                        height_m1 <= h_m1[CTB_CNT_W-1:0];
                        ctu_x     <= '0;
                        ctu_y     <= '0;
                        ctu_addr  <= '0;
                        init_req  <= 1'b1;
                        state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    // First CTU is issued straight off the init ack.
                    if (init_done) begin
                        init_req  <= 1'b0;
                        ctu_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ctu_start <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (ctu_done) begin
                        if (ctu_eos) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (last_x && last_y) begin
                            status[1] <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            if (last_x) begin
                                ctu_x <= '0;
                                ctu_y <= ctu_y + 1'b1;
                            end else begin
                                ctu_x <= ctu_x + 1'b1;
                            end
                            ctu_addr <= ctu_addr + 1'b1;
                            state    <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    // Coordinates advanced last cycle; ctu_start follows one
                    // cycle later so they are settled when it is seen.
                    ctu_start <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
